// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the button event arbiter.
// Latency: n/a (types and a combinational round-robin helper only).
// Backpressure: n/a.
package btn_arb_pkg;

  // Output slot: either holding an event for the consumer or idle.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Widest request vector the round-robin helper handles (2 x 8 buttons).
  localparam int MAX_SRC = 16;

  // Reset pointer sits this far below the source count, so source 0 is searched first.
  localparam int RR_RST_OFS = 1;

  // Round-robin pick: first set bit of req at or after rr+1, wrapping modulo n_src.
  // Returns rr unchanged when nothing is requested (the caller gates on |req).
  function automatic logic [3:0] rr_winner(input logic [MAX_SRC-1:0] req,
                                           input logic [3:0]         rr,
                                           input logic [4:0]         n_src);
    logic [5:0] idx;
    logic [3:0] win;
    logic       found;
    win   = rr;
    found = 1'b0;
    for (int i = 1; i <= MAX_SRC; i++) begin
      idx = 6'(rr) + 6'(i);
      if (idx >= 6'(n_src)) idx = idx - 6'(n_src);
      if (!found && (6'(i) <= 6'(n_src)) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the arbiter and its single consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds ev_ready low; producer keeps ev_valid/ev_id/ev_rel stable.
interface btn_event_arbiter_if #(
  parameter int ID_W = 2
) ();

  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic            ev_rel;
  logic            ev_ready;

  modport master (output ev_valid, output ev_id, output ev_rel, input ev_ready);
  modport slave  (input ev_valid, input ev_id, input ev_rel, output ev_ready);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, run-length debouncer, registered rise/fall pulses.
// Latency: input level to pulse is 2 sync edges + DEB_CYCLES stable samples.
// Backpressure: none; pulses are single-cycle and must be captured by the caller.
module btn_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q;
  logic             s_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, fall_q;
  logic             flip;

  // Count samples that disagree with the debounced level; flip after DEB_CYCLES in a row.
  always_comb begin
    flip  = (s_q != deb_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    deb_d = flip ? ~deb_q : deb_q;
    cnt_d = ((s_q == deb_q) || flip) ? '0 : cnt_q + CNT_W'(1);
  end

  // Synchronizer, debounce state and edge pulses, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      s_q     <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= flip & ~deb_q;
      fall_q  <= flip & deb_q;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced button presses latched as pending events, served round-robin over one valid/ready port.
// Latency: btn held from edge k -> pending at k+2+DEB_CYCLES, ev_valid at k+3+DEB_CYCLES if slot free.
// Backpressure: slot holds while ev_ready=0; presses on an already-pending button pulse drop.
// Optional: define RELEASE_EVENT_EN to also report release edges (ev_rel=1) as separate sources.
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_BTN-1:0]        btn,
  btn_event_arbiter_if.master     ev,
  output logic [N_BTN-1:0]        pending,
  output logic [N_BTN-1:0]        drop
);

  localparam int ID_W = $clog2(N_BTN);
`ifdef RELEASE_EVENT_EN
  localparam int N_SRC = 2 * N_BTN;
`else
  localparam int N_SRC = N_BTN;
`endif
  localparam int             RR_W   = $clog2(N_SRC);
  localparam logic [RR_W-1:0] RR_RST = RR_W'(N_SRC - RR_RST_OFS);

  logic [N_BTN-1:0] deb, rise, fall;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] drop_q, drop_d;
  logic [N_SRC-1:0] req, grant;
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [3:0]       win;
  logic             load;
  slot_state_e      state_q, state_d;
`ifdef RELEASE_EVENT_EN
  logic [N_BTN-1:0] pend_rel_q, pend_rel_d;
  logic             rel_q, rel_d;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[i]),
      .deb_o  (deb[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  // Levels are only needed as edges here; release edges are only used with the option.
  logic unused_ok;
  assign unused_ok = ^{deb, fall};

  // Request order: presses 0..N-1, then releases 0..N-1 when enabled.
`ifdef RELEASE_EVENT_EN
  assign req = {pend_rel_q, pend_q};
`else
  assign req = pend_q;
`endif
  assign win = rr_winner(MAX_SRC'(req), 4'(rr_q), 5'(N_SRC));

  // Slot FSM: fill when empty, refill on accept without a bubble, empty when nothing waits.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (|req) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ev.ev_ready) begin
          if (|req) load = 1'b1;
          else      state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Grant decode: the winner's bit is cleared, pointer and slot contents advance.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    id_d  = id_q;
`ifdef RELEASE_EVENT_EN
    rel_d = rel_q;
`endif
    if (load) begin
      grant[win[RR_W-1:0]] = 1'b1;
      rr_d                 = win[RR_W-1:0];
`ifdef RELEASE_EVENT_EN
      if (win >= 4'(N_BTN)) begin
        id_d  = ID_W'(win - 4'(N_BTN));
        rel_d = 1'b1;
      end else begin
        id_d  = ID_W'(win);
        rel_d = 1'b0;
      end
`else
      id_d = ID_W'(win);
`endif
    end
  end

  // Pending flags: a new edge on a granted bit re-arms it; on a non-granted pending bit it is lost.
  always_comb begin
    pend_d = (pend_q & ~grant[N_BTN-1:0]) | rise;
    drop_d = rise & pend_q & ~grant[N_BTN-1:0];
`ifdef RELEASE_EVENT_EN
    pend_rel_d = (pend_rel_q & ~grant[N_SRC-1:N_BTN]) | fall;
    drop_d     = drop_d | (fall & pend_rel_q & ~grant[N_SRC-1:N_BTN]);
`endif
  end

  // State registers; reset discards any event in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rr_q    <= RR_RST;
      id_q    <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
`ifdef RELEASE_EVENT_EN
      pend_rel_q <= '0;
      rel_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
`ifdef RELEASE_EVENT_EN
      pend_rel_q <= pend_rel_d;
      rel_q      <= rel_d;
`endif
    end
  end

  assign ev.ev_valid = (state_q == FULL);
  assign ev.ev_id    = id_q;
`ifdef RELEASE_EVENT_EN
  assign ev.ev_rel   = rel_q;
`else
  assign ev.ev_rel   = 1'b0;
`endif
  assign pending = pend_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: cycle model of the event rules plus directed literal checks.
// Latency: n/a.
// Backpressure: exercised by holding ev_ready low during the directed scenarios.
module tb_btn_event_arbiter;

  localparam int N   = 4;
  localparam int DEB = 4;
`ifdef RELEASE_EVENT_EN
  localparam int M = 2 * N;
`else
  localparam int M = N;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn;
  logic         ready;
  logic [N-1:0] pending;
  logic [N-1:0] drop;

  btn_event_arbiter_if #(.ID_W($clog2(N))) ev_if ();
  assign ev_if.ev_ready = ready;

  btn_event_arbiter #(.N_BTN(N), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .ev      (ev_if),
    .pending (pending),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_n  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce: level flips once the last DEB synchronized samples all disagree with it.
  // Synchronized sample at an edge is the raw sample taken two edges earlier (sh[i][1]).
  bit [DEB:0]   sh [N];
  bit [N-1:0]   m_deb, m_rise, m_fall, m_pend, m_prel, m_drop;
  bit           m_valid, m_rel;
  int           m_id, m_rr;

  always @(posedge clk) begin
    bit [2*N-1:0] req;
    bit [2*N-1:0] gnt;
    int           w;
    bit           flip;
    if (reset) begin
      m_deb = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_prel = '0; m_drop = '0;
      m_valid = 1'b0; m_rel = 1'b0; m_id = 0; m_rr = M - 1;
      for (int i = 0; i < N; i++) sh[i] = '0;
    end else begin
      req = {m_prel, m_pend};
      gnt = '0;
      if (!m_valid || ready) begin
        w = -1;
        for (int k = 1; k <= M; k++)
          if (w < 0 && req[(m_rr + k) % M]) w = (m_rr + k) % M;
        if (w >= 0) begin
          m_valid = 1'b1; m_id = w % N; m_rel = (w >= N); m_rr = w; gnt[w] = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_drop = '0;
      for (int i = 0; i < N; i++) begin
        if (m_rise[i] && m_pend[i] && !gnt[i]) m_drop[i] = 1'b1;
        m_pend[i] = (m_pend[i] && !gnt[i]) || m_rise[i];
`ifdef RELEASE_EVENT_EN
        if (m_fall[i] && m_prel[i] && !gnt[N+i]) m_drop[i] = 1'b1;
        m_prel[i] = (m_prel[i] && !gnt[N+i]) || m_fall[i];
`endif
      end
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) if (sh[i][j] == m_deb[i]) flip = 1'b0;
        m_rise[i] = flip && !m_deb[i];
        m_fall[i] = flip && m_deb[i];
        if (flip) m_deb[i] = !m_deb[i];
        sh[i] = {sh[i][DEB-1:0], btn[i]};
      end
    end
  end

  // Accepted-event counter, used to pin how many events a scenario produced.
  always @(posedge clk) if (!reset && ev_if.ev_valid && ready) acc_n++;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_valid", 32'(ev_if.ev_valid), 32'(m_valid));
    if (m_valid) chk("cyc_id", 32'(ev_if.ev_id), 32'(m_id));
    chk("cyc_rel", 32'(ev_if.ev_rel), 32'(m_valid ? m_rel : ev_if.ev_rel));
    chk("cyc_pending", 32'(pending), 32'(m_pend));
    chk("cyc_drop", 32'(drop), 32'(m_drop));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  int acc0;

  initial begin
    reset = 1'b1; btn = '0; ready = 1'b0;
    tick(2);
    chk("rst_valid", 32'(ev_if.ev_valid), 0);
    chk("rst_id", 32'(ev_if.ev_id), 0);
    chk("rst_rel", 32'(ev_if.ev_rel), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop), 0);
    reset = 1'b0;

    // Clean press on btn2 with a ready consumer.
    ready = 1'b1;
    tick(2);
    btn[2] = 1'b1;
    tick(DEB + 2);
    chk("press_pend_early", 32'(pending), 0);
    tick(1);
    chk("press_pend", 32'(pending), 32'h4);
    chk("press_valid_early", 32'(ev_if.ev_valid), 0);
    tick(1);
    chk("press_valid", 32'(ev_if.ev_valid), 1);
    chk("press_id", 32'(ev_if.ev_id), 2);
    chk("press_pend_clr", 32'(pending), 0);
    tick(1);
    chk("press_one_cycle", 32'(ev_if.ev_valid), 0);
    btn = '0;
    tick(DEB + 4);

    // Glitch of three samples on btn1.
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(DEB + 6);
    chk("glitch_pend", 32'(pending), 0);
    chk("glitch_valid", 32'(ev_if.ev_valid), 0);

    // Backpressure and round-robin on simultaneous presses 0,1,3.
    do_reset();
    ready = 1'b0;
    btn = 4'b1011;
    tick(DEB + 4);
    chk("bp_valid", 32'(ev_if.ev_valid), 1);
    chk("bp_id", 32'(ev_if.ev_id), 0);
    chk("bp_pend", 32'(pending), 32'ha);
    tick(3);
    chk("bp_hold_id", 32'(ev_if.ev_id), 0);
    chk("bp_hold_valid", 32'(ev_if.ev_valid), 1);
    ready = 1'b1;
    tick(1);
    chk("rr_id1", 32'(ev_if.ev_id), 1);
    chk("rr_valid1", 32'(ev_if.ev_valid), 1);
    tick(1);
    chk("rr_id3", 32'(ev_if.ev_id), 3);
    chk("rr_valid3", 32'(ev_if.ev_valid), 1);
    tick(1);
    chk("rr_empty", 32'(ev_if.ev_valid), 0);
    btn = '0;
    tick(DEB + 4);

    // Drop: third press on btn1 while one event sits in the slot and one is pending.
    do_reset();
    acc0 = acc_n;
    ready = 1'b0;
    btn[1] = 1'b1;
    tick(DEB + 4);
    chk("drop_slot_id", 32'(ev_if.ev_id), 1);
    chk("drop_slot_pend", 32'(pending), 0);
    btn[1] = 1'b0;
    tick(DEB + 3);
    btn[1] = 1'b1;
    tick(DEB + 3);
    chk("drop_pend1", 32'(pending), 32'h2);
    chk("drop_none_yet", 32'(drop), 0);
    btn[1] = 1'b0;
    tick(DEB + 3);
    btn[1] = 1'b1;
    tick(DEB + 2);
    chk("drop_pre", 32'(drop), 0);
    tick(1);
    chk("drop_pulse", 32'(drop), 32'h2);
    tick(1);
    chk("drop_post", 32'(drop), 0);
    ready = 1'b1;
    tick(1);
    chk("drop_second_valid", 32'(ev_if.ev_valid), 1);
    chk("drop_second_id", 32'(ev_if.ev_id), 1);
    tick(1);
    chk("drop_drained", 32'(ev_if.ev_valid), 0);
    chk("drop_event_count", 32'(acc_n - acc0), 2);
    btn = '0;
    tick(DEB + 4);

    // Reset while an event is held and two more are pending.
    do_reset();
    ready = 1'b0;
    btn = 4'b1011;
    tick(DEB + 4);
    chk("mid_valid", 32'(ev_if.ev_valid), 1);
    chk("mid_pend", 32'(pending), 32'ha);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(ev_if.ev_valid), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    reset = 1'b0;
    tick(DEB + 3);
    chk("mid_re_valid_early", 32'(ev_if.ev_valid), 0);
    chk("mid_re_pend", 32'(pending), 32'hb);
    tick(1);
    chk("mid_re_valid", 32'(ev_if.ev_valid), 1);
    chk("mid_re_id", 32'(ev_if.ev_id), 0);
    ready = 1'b1;
    tick(3);
    btn = '0;
    tick(DEB + 4);

    // Press then release of btn3.
    do_reset();
    ready = 1'b1;
    btn[3] = 1'b1;
    tick(DEB + 4);
    chk("rel_press_valid", 32'(ev_if.ev_valid), 1);
    chk("rel_press_id", 32'(ev_if.ev_id), 3);
    chk("rel_press_rel", 32'(ev_if.ev_rel), 0);
    btn[3] = 1'b0;
    tick(DEB + 4);
`ifdef RELEASE_EVENT_EN
    chk("rel_event_valid", 32'(ev_if.ev_valid), 1);
    chk("rel_event_id", 32'(ev_if.ev_id), 3);
    chk("rel_event_rel", 32'(ev_if.ev_rel), 1);
`else
    chk("rel_ignored", 32'(ev_if.ev_valid), 0);
    chk("rel_tied", 32'(ev_if.ev_rel), 0);
`endif
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
Shared front end for the push-button inputs of the lab FSMs. Each raw button is synchronized, debounced and edge-detected, and each press is latched as a pending event. A round-robin arbiter then presents one event at a time to a single downstream consumer (sequence detector / Mealy controller) over a valid/ready handshake. This replaces per-FSM debouncers and gives the consumer one clean, ordered event stream.

Parameters:
N_BTN, 4, number of button inputs (2..8)
DEB_CYCLES, 8, consecutive stable synchronized samples required to change debounced state (>=2)
ID_W, $clog2(N_BTN), width of event id (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
btn  in  N_BTN  raw asynchronous button levels, 1 = pressed
ev_valid  out  1  event available
ev_id  out  ID_W  index of the button that produced the event
ev_rel  out  1  1 = release event (only with RELEASE_EVENT_EN; otherwise tied 0)
ev_ready  in  1  consumer accepts the event
pending  out  N_BTN  pending press flags (debug/status)
drop  out  N_BTN  1-cycle pulse: press lost because that button was already pending

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: ev_valid=0, ev_id=0, ev_rel=0, pending=0, drop=0, all debounced states=0, sync flops=0, debounce counters=0, rr pointer=N_BTN-1 (btn0 has first priority).
- Sync: 2-flop synchronizer per button; s[i] follows btn[i] 2 edges later.
- Debounce: counter clears whenever s[i]==deb[i]; counts while s[i]!=deb[i]; on the edge where count==DEB_CYCLES-1 and s[i]!=deb[i] still holds, deb[i] flips and counter clears. A glitch shorter than DEB_CYCLES samples produces no change.
- Press detect: deb[i] 0->1 sets pending[i] on the same edge. If pending[i] is already 1 and is not being granted that edge, pulse drop[i].
- Latency: btn held from edge k gives pending at edge k+2+DEB_CYCLES and ev_valid at edge k+3+DEB_CYCLES if the output slot is free (DEB_CYCLES+3 cycles).
- Output slot FSM, 2 states:
  - EMPTY: if any pending, load the winner into ev_id, clear its pending bit, set ev_valid, go to FULL.
  - FULL: hold ev_valid/ev_id/ev_rel stable while ev_ready=0. On ev_valid&ev_ready, if any pending, load the next winner on the same edge (back-to-back, no bubble) and stay FULL; else deassert ev_valid and go to EMPTY.
- Round-robin: search starts at rr+1 mod N_BTN and takes the first pending bit; on each grant rr:=granted id.
- Simultaneous events: grant-clear and new set on the same bit in the same edge leaves pending=1 with no drop. Multiple presses on the same edge all set their pending bits.
- Button held through reset: deb=0 and s=1 after reset, so it registers as a fresh press after DEB_CYCLES.
- Reset mid-handshake: the event in flight is discarded; no event is replayed.

Optional Feature:
RELEASE_EVENT_EN
- Defined: deb 1->0 sets a separate pend_rel[i] with its own drop behaviour, which pulses the same drop[i]. The arbiter covers 2*N_BTN sources, ordered press0..pressN-1 then rel0..relN-1, with one rr pointer over all of them. ev_rel=1 marks a release event. pending shows press flags only.
- Undefined: release edges are ignored and ev_rel is constant 0.

Decomposition:
- Package btn_arb_pkg: slot state enum (EMPTY, FULL); function returning the round-robin winner index; localparam for the reset rr value.
- Sub-module btn_debounce (params DEB_CYCLES): 2-flop sync, counter, deb output, registered rise/fall pulses. Instantiated N_BTN times in a generate loop.

Test Plan (N_BTN=4, DEB_CYCLES=4):
- Clean press: btn[2] rises at edge 10 and holds, ev_ready=1 -> pending[2] at edge 16, ev_valid=1 with ev_id=2 at edge 17 for exactly one cycle.
- Glitch rejection: btn[1] high for 3 cycles, then low -> pending stays 0, ev_valid never asserts.
- Backpressure and round-robin: buttons 0, 1 and 3 pressed on the same cycle, ev_ready=0 -> ev_id=0 held stable; then ev_ready=1 -> ids 0, 1, 3 accepted on consecutive cycles with no bubble, then ev_valid=0.
- Drop: with ev_ready=0, btn[1] pressed (granted into slot), released, pressed (pending[1]=1), released, pressed again -> drop[1] pulses once; after draining, only two id=1 events are observed.
- Reset mid-operation: reset asserted 1 cycle while ev_valid=1 and pending=4'b1010 -> next edge: ev_valid=0, pending=0; a button still held produces a new event DEB_CYCLES+3 cycles after reset deasserts.
- RELEASE_EVENT_EN: press then release btn[3] -> two events, id=3 with ev_rel=0, then id=3 with ev_rel=1.
